// File: rtl/adc_buf_pkg.sv
// Shared constants, capture state encoding and wrap-around address helpers
// for the ADC sample ring buffer.
package adc_buf_pkg;

  localparam int ADC_DEPTH = 5120;
  localparam int ADC_AW    = 13;
  localparam int ADC_DW    = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ARMED,
    ST_POST,
    ST_READ
  } cap_state_t;

  // (a + b) reduced into [0, depth); a and b must already be below depth.
  // The sum is formed one bit wider than an address so it cannot overflow.
  function automatic logic [ADC_AW-1:0] addr_wrap_add(
    input logic [ADC_AW-1:0] a,
    input logic [ADC_AW-1:0] b,
    input logic [ADC_AW:0]   depth
  );
    logic [ADC_AW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= depth) sum = sum - depth;
    return sum[ADC_AW-1:0];
  endfunction

  // Address increment that wraps depth-1 back to 0.
  function automatic logic [ADC_AW-1:0] addr_wrap_inc(
    input logic [ADC_AW-1:0] a,
    input logic [ADC_AW:0]   depth
  );
    return addr_wrap_add(a, ADC_AW'(1), depth);
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_skid.sv
// Two-entry output FIFO between the RAM read port and the valid/ready
// consumer. Soaks up the one read that is already in flight when the
// consumer stalls. Each entry holds {last, data}.
module adc_rd_skid #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;

  // Entry 0 is always the head; entry 1 only fills while the head waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else if (flush) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= push_data;
          else             ent1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            ent0 <= ent1;
            ent1 <= push_data;
          end else begin
            ent0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Pre/post-trigger ring-buffer capture engine for the ADC sample BSRAM.
// Owns the single RAM port: writes samples while capturing, then streams
// PRE+POST samples out in address order on a valid/ready interface.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for arm; RAM untouched
//   ST_FILL  | writing the first PRE samples so the pre-trigger window is full
//   ST_ARMED | writing continuously, waiting for trigger
//   ST_POST  | writing until POST samples from the trigger are stored
//   ST_READ  | reading PRE+POST samples out through the skid buffer
//
// The address helpers in adc_buf_pkg are sized for ADC_AW, so AW is
// expected to stay at its default.
module adc_capture_ctrl
  import adc_buf_pkg::*;
#(
  parameter int DEPTH = ADC_DEPTH,
  parameter int AW    = ADC_AW,
  parameter int DW    = ADC_DW,
  parameter int PRE   = 1024,
  parameter int POST  = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          abort,
  input  logic          trigger,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic          done,
  output logic          ram_ce,
  output logic          ram_oce,
  output logic          ram_wre,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int CW = AW + 1;
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] RD_OFS   = AW'(DEPTH - PRE);
  localparam logic [CW-1:0] PRE_M1   = CW'(PRE - 1);
  localparam logic [CW-1:0] POST_M1  = CW'(POST - 1);
  localparam logic [CW-1:0] TOTAL_C  = CW'(PRE + POST);
  localparam logic [CW-1:0] TOTAL_M1 = CW'(PRE + POST - 1);

  cap_state_t state_q, state_d;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] trig_base;
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] post_cnt;
  logic [CW-1:0] rd_cnt;
  logic          rd_inflight;
  logic          rd_inflight_last;
  logic          wr_en;
  logic          rd_issue;
  logic          rd_pop;
  logic          hs_last;
  logic          room;
  logic [2:0]    occ_next;
  logic [1:0]    skid_occ;
  logic [DW:0]   skid_head;

  assign rd_valid  = (skid_occ != 2'd0);
  assign rd_pop    = rd_valid & rd_ready;
  assign rd_data   = skid_head[DW-1:0];
  assign rd_last   = rd_valid & skid_head[DW];
  assign hs_last   = rd_pop & skid_head[DW];
  assign busy      = (state_q != ST_IDLE);
  assign ram_oce   = 1'b1;
  // Buffer level after this edge, counting the read already in flight.
  assign occ_next  = {1'b0, skid_occ} + {2'b0, rd_inflight} - {2'b0, rd_pop};
  assign room      = (occ_next <= 3'd1);
  // When the last post sample lands in the trigger cycle itself, trig_addr
  // has not been latched yet, so take it straight from wr_ptr.
  assign trig_base = (state_q == ST_ARMED) ? wr_ptr : trig_addr;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and RAM port drive; abort overrides every transition.
  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    rd_issue = 1'b0;
    ram_ce   = 1'b0;
    ram_wre  = 1'b0;
    ram_ad   = '0;
    ram_din  = '0;
    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_FILL;
      end
      ST_FILL: begin
        wr_en = adc_valid;
        if (adc_valid && fill_cnt == PRE_M1) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        wr_en = adc_valid;
        if (trigger) begin
          if (adc_valid && POST_M1 == '0) state_d = ST_READ;
          else                            state_d = ST_POST;
        end
      end
      ST_POST: begin
        wr_en = adc_valid;
        if (adc_valid && post_cnt == POST_M1) state_d = ST_READ;
      end
      ST_READ: begin
        rd_issue = (rd_cnt != TOTAL_C) && room;
        if (hs_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;

    if (wr_en) begin
      ram_ce  = 1'b1;
      ram_wre = 1'b1;
      ram_ad  = wr_ptr;
      ram_din = adc_data;
    end else if (rd_issue) begin
      ram_ce = 1'b1;
      ram_ad = rd_ptr;
    end
  end

  // Pointers, sample counters, in-flight read tracking and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      trig_addr        <= '0;
      fill_cnt         <= '0;
      post_cnt         <= '0;
      rd_cnt           <= '0;
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
      done             <= 1'b0;
    end else begin
      if (abort) begin
        rd_inflight      <= 1'b0;
        rd_inflight_last <= 1'b0;
        done             <= 1'b0;
      end else begin
        rd_inflight      <= rd_issue;
        rd_inflight_last <= rd_issue && (rd_cnt == TOTAL_M1);
        done             <= hs_last;
      end

      if (state_q == ST_IDLE && arm) begin
        wr_ptr   <= '0;
        fill_cnt <= '0;
      end else if (wr_en) begin
        wr_ptr <= addr_wrap_inc(wr_ptr, DEPTH_W);
        if (state_q == ST_FILL) fill_cnt <= fill_cnt + CW'(1);
      end

      if (state_q == ST_ARMED && trigger) begin
        trig_addr <= wr_ptr;
        post_cnt  <= adc_valid ? CW'(1) : '0;
      end else if (state_q == ST_POST && wr_en) begin
        post_cnt <= post_cnt + CW'(1);
      end

      if (state_q != ST_READ && state_d == ST_READ) begin
        rd_ptr <= addr_wrap_add(trig_base, RD_OFS, DEPTH_W);
        rd_cnt <= '0;
      end else if (rd_issue) begin
        rd_ptr <= addr_wrap_inc(rd_ptr, DEPTH_W);
        rd_cnt <= rd_cnt + CW'(1);
      end
    end
  end

  adc_rd_skid #(.W(DW + 1)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort),
    .push      (rd_inflight),
    .push_data ({rd_inflight_last, ram_dout}),
    .pop       (rd_pop),
    .head      (skid_head),
    .occ       (skid_occ)
  );

endmodule
